// File: rtl/dbg_view_sched.sv
// dbg_view_sched: picks the 7-segment debug word from the instr, RF, ALU or DM view.
// RF and DM words are fetched over req/ack read ports; the display word is registered.
module dbg_view_sched #(
  parameter int DM_DATA_NUM = 7,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        step_i,
  input  logic [3:0]  mode_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] alu_a_i,
  input  logic [31:0] alu_b_i,
  input  logic [31:0] alu_c_i,
  input  logic        alu_zero_i,
  output logic        rf_req_o,
  output logic [4:0]  rf_addr_o,
  input  logic        rf_ack_i,
  input  logic [31:0] rf_data_i,
  output logic        dm_req_o,
  output logic [5:0]  dm_addr_o,
  input  logic        dm_ack_i,
  input  logic [31:0] dm_data_i,
  output logic [31:0] disp_data_o,
  output logic        disp_valid_o,
  output logic        busy_o,
  output logic        timeout_o
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic [4:0] rf_idx;
  logic [5:0] dm_idx;
  logic [2:0] alu_ph;
  logic [7:0] cnt;
  logic [3:0] mode_q;
  logic one_hot, v_instr, v_rf, v_alu, v_dm, chg, stp, marker, ack, tmo, done;
  logic [31:0] alu_word;
  logic unused_dm;
  assign unused_dm = ^dm_data_i[31:8];
  assign busy_o = (state == WAIT);
  always_comb begin
    one_hot  = (mode_i != 4'd0) && ((mode_i & (mode_i - 4'd1)) == 4'd0);
    v_instr  = !one_hot || mode_i[3];
    v_rf     = one_hot && mode_i[2];
    v_alu    = one_hot && mode_i[1];
    v_dm     = one_hot && mode_i[0];
    chg      = (mode_i != mode_q);
    stp      = step_i && !chg && (state == IDLE);
    marker   = (dm_idx == 6'(DM_DATA_NUM));
    ack      = (state == WAIT) && (rf_req_o ? rf_ack_i : dm_ack_i);
    tmo      = (state == WAIT) && !ack && (cnt == 8'(ACK_TIMEOUT - 1));
    done     = (state == WAIT) && !chg && (ack || tmo);
    state_n  = (state == IDLE) ? ((stp && (v_rf || (v_dm && !marker))) ? WAIT : IDLE)
                               : ((chg || ack || tmo) ? IDLE : WAIT);
    alu_word = (alu_ph == 3'd0) ? 32'hFFFF_FFFF :
               (alu_ph == 3'd1) ? alu_a_i :
               (alu_ph == 3'd2) ? alu_b_i :
               (alu_ph == 3'd3) ? alu_c_i : {31'b0, alu_zero_i};
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rf_idx       <= '0;
      dm_idx       <= '0;
      alu_ph       <= '0;
      cnt          <= '0;
      mode_q       <= '0;
      rf_req_o     <= 1'b0;
      rf_addr_o    <= '0;
      dm_req_o     <= 1'b0;
      dm_addr_o    <= '0;
      disp_data_o  <= '0;
      disp_valid_o <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      mode_q       <= mode_i;
      disp_valid_o <= 1'b0;
      timeout_o    <= 1'b0;
      cnt          <= (state == WAIT && state_n == WAIT) ? cnt + 8'd1 : 8'd0;
      rf_req_o     <= (state_n == WAIT) && ((state == WAIT) ? rf_req_o : v_rf);
      dm_req_o     <= (state_n == WAIT) && ((state == WAIT) ? dm_req_o : v_dm);
      if (stp && v_rf) rf_addr_o <= rf_idx;
      if (stp && v_dm && !marker) dm_addr_o <= dm_idx;
      if (chg) begin
        rf_idx <= '0;
        dm_idx <= '0;
        alu_ph <= '0;
      end else if (stp && v_alu) begin
        disp_data_o  <= alu_word;
        disp_valid_o <= 1'b1;
        alu_ph       <= (alu_ph == 3'd4) ? 3'd0 : alu_ph + 3'd1;
      end else if (stp && v_dm && marker) begin
        disp_data_o  <= 32'hFFFF_FFFF;
        disp_valid_o <= 1'b1;
        dm_idx       <= '0;
      end else if (done) begin
        disp_data_o  <= tmo ? 32'hDEAD_DEAD : (rf_req_o ? rf_data_i : {24'b0, dm_data_i[7:0]});
        disp_valid_o <= 1'b1;
        timeout_o    <= tmo;
        if (rf_req_o) rf_idx <= rf_idx + 5'd1;
        else dm_idx <= dm_idx + 6'd1;
      end
      if (v_instr) disp_data_o <= instr_i;
    end
  end
endmodule

// File: tb/tb_dbg_view_sched.sv
// tb_dbg_view_sched: directed/randomised checks of the debug-view scheduler against
// per-view index counters kept in the bench.
module tb_dbg_view_sched;
  localparam int N = 7;
  logic        clk = 1'b0, rstn = 1'b0, step_i = 1'b0;
  logic [3:0]  mode_i = 4'd0;
  logic [31:0] instr_i = '0, alu_a_i = '0, alu_b_i = '0, alu_c_i = '0;
  logic        alu_zero_i = 1'b0, rf_ack_i = 1'b0, dm_ack_i = 1'b0;
  logic [31:0] rf_data_i = '0, dm_data_i = '0;
  logic        rf_req_o, dm_req_o, disp_valid_o, busy_o, timeout_o;
  logic [4:0]  rf_addr_o;
  logic [5:0]  dm_addr_o;
  logic [31:0] disp_data_o;
  int checks = 0, errors = 0, vcount = 0;

  dbg_view_sched dut (
    .clk(clk), .rstn(rstn), .step_i(step_i), .mode_i(mode_i), .instr_i(instr_i),
    .alu_a_i(alu_a_i), .alu_b_i(alu_b_i), .alu_c_i(alu_c_i), .alu_zero_i(alu_zero_i),
    .rf_req_o(rf_req_o), .rf_addr_o(rf_addr_o), .rf_ack_i(rf_ack_i), .rf_data_i(rf_data_i),
    .dm_req_o(dm_req_o), .dm_addr_o(dm_addr_o), .dm_ack_i(dm_ack_i), .dm_data_i(dm_data_i),
    .disp_data_o(disp_data_o), .disp_valid_o(disp_valid_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (disp_valid_o) vcount++;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_mode(input logic [3:0] m);
    @(negedge clk) mode_i = m;
    @(negedge clk);
  endtask

  // caller sits at a negedge; returns at the negedge of cycle T+1
  task automatic pulse_step();
    step_i = 1'b1;
    @(negedge clk) step_i = 1'b0;
  endtask

  task automatic rf_step(input int dly, input int idx);
    pulse_step();
    chk("rf_req", {31'b0, rf_req_o}, 1);
    chk("rf_addr", {27'b0, rf_addr_o}, idx);
    chk("rf_dm_quiet", {31'b0, dm_req_o}, 0);
    repeat (dly) @(negedge clk);
    chk("rf_req_hold", {31'b0, rf_req_o}, 1);
    rf_data_i = 32'h1000 + idx;
    rf_ack_i = 1'b1;
    @(negedge clk) rf_ack_i = 1'b0;
    chk("rf_valid", {31'b0, disp_valid_o}, 1);
    chk("rf_disp", disp_data_o, 32'h1000 + idx);
    chk("rf_req_drop", {31'b0, rf_req_o}, 0);
  endtask

  task automatic dm_step(input int idx);
    pulse_step();
    if (idx == N) begin
      chk("dm_marker_valid", {31'b0, disp_valid_o}, 1);
      chk("dm_marker", disp_data_o, 32'hFFFF_FFFF);
      chk("dm_marker_noreq", {31'b0, dm_req_o}, 0);
    end else begin
      chk("dm_req", {31'b0, dm_req_o}, 1);
      chk("dm_addr", {26'b0, dm_addr_o}, idx);
      chk("dm_rf_quiet", {31'b0, rf_req_o}, 0);
      dm_data_i = {24'($urandom), 8'(idx)};
      dm_ack_i = 1'b1;
      @(negedge clk) dm_ack_i = 1'b0;
      chk("dm_valid", {31'b0, disp_valid_o}, 1);
      chk("dm_disp", disp_data_o, 32'(idx));
    end
  endtask

  initial begin
    logic [31:0] words [5];
    logic [31:0] held;
    int v0, n, tmo_seen;
    // reset state
    #2;
    chk("rst_disp", disp_data_o, 0);
    chk("rst_outs", {26'b0, rf_req_o, dm_req_o, disp_valid_o, busy_o, timeout_o, 1'b0}, 0);
    @(negedge clk) rstn = 1'b1;
    set_mode(4'b0100);
    pulse_step();
    chk("pre_rst_req", {31'b0, rf_req_o}, 1);
    #1 rstn = 1'b0;
    #1;
    chk("async_rst_req", {31'b0, rf_req_o}, 0);
    chk("async_rst_busy", {31'b0, busy_o}, 0);
    chk("async_rst_disp", disp_data_o, 0);
    @(negedge clk) begin
      rstn = 1'b1;
      mode_i = 4'b1000;
      instr_i = 32'h00A0_0093;
    end
    @(negedge clk) chk("instr_first", disp_data_o, 32'h00A0_0093);
    // instr view, including invalid modes
    for (int i = 0; i < 4; i++) begin
      instr_i = $urandom;
      mode_i = (i == 2) ? 4'b0000 : (i == 3) ? 4'b0110 : 4'b1000;
      @(negedge clk);
      chk("instr_disp", disp_data_o, instr_i);
      chk("instr_novalid", {31'b0, disp_valid_o}, 0);
    end
    pulse_step();
    chk("instr_step_ignored", {30'b0, rf_req_o, dm_req_o}, 0);
    // RF scan
    set_mode(4'b0100);
    v0 = vcount;
    for (int i = 0; i < 33; i++) rf_step((i < 16) ? 3 : int'($urandom_range(0, 8)), i % 32);
    @(negedge clk) chk("rf_valid_count", vcount - v0, 33);
    // ALU cycle
    set_mode(4'b0010);
    alu_a_i = 5; alu_b_i = 7; alu_c_i = 12; alu_zero_i = 1'b0;
    for (int k = 0; k < 11; k++) begin
      if (k == 6) begin
        alu_a_i = $urandom; alu_b_i = $urandom; alu_c_i = $urandom; alu_zero_i = 1'b1;
      end
      words[0] = 32'hFFFF_FFFF; words[1] = alu_a_i; words[2] = alu_b_i;
      words[3] = alu_c_i; words[4] = {31'b0, alu_zero_i};
      pulse_step();
      chk("alu_valid", {31'b0, disp_valid_o}, 1);
      chk("alu_disp", disp_data_o, words[k % 5]);
      chk("alu_noreq", {30'b0, rf_req_o, dm_req_o}, 0);
    end
    // DM scan with end marker and wrap
    set_mode(4'b0001);
    for (int k = 0; k < 12; k++) dm_step(k % (N + 1));
    // timeout in RF view
    set_mode(4'b0100);
    pulse_step();
    n = 0;
    while (rf_req_o && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_req_cycles", n, 15);
    chk("tmo_pulse", {31'b0, timeout_o}, 1);
    chk("tmo_disp", disp_data_o, 32'hDEAD_DEAD);
    chk("tmo_busy", {31'b0, busy_o}, 0);
    @(negedge clk) chk("tmo_once", {31'b0, timeout_o}, 0);
    rf_step(0, 1);
    // mode change mid-WAIT with a step in the switch cycle
    pulse_step();
    chk("mc_req_pending", {31'b0, rf_req_o}, 1);
    held = disp_data_o;
    mode_i = 4'b0001;
    step_i = 1'b1;
    @(negedge clk) step_i = 1'b0;
    chk("mc_rf_drop", {31'b0, rf_req_o}, 0);
    chk("mc_step_dropped", {31'b0, dm_req_o}, 0);
    chk("mc_novalid", {31'b0, disp_valid_o}, 0);
    chk("mc_hold", disp_data_o, held);
    tmo_seen = 0;
    repeat (20) @(negedge clk) if (timeout_o || disp_valid_o) tmo_seen++;
    chk("mc_no_timeout", tmo_seen, 0);
    dm_step(0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dbg_view_sched.md
# dbg_view_sched

Debug-view scheduler for the single-cycle RISC-V CPU top level. It arbitrates the 7-segment display source between instruction, register-file, ALU-probe and data-memory views. Register-file and data-memory views are read through req/ack debug read ports instead of direct hierarchical access. On each step tick it advances the selected view's index, fetches the word, and presents it to seg7x16 as a registered 32-bit value.

## Interface
- DM_DATA_NUM, 7: number of DM bytes scanned before the 32'hFFFFFFFF end marker.
- ACK_TIMEOUT, 15: cycles to wait for an ack before aborting a read (1..255).
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- step_i  in  1  one-cycle advance pulse (from the display clock divider)
- mode_i  in  4  view select, one-hot: [3] instr, [2] reg, [1] alu, [0] dm
- instr_i  in  32  current instruction word
- alu_a_i, alu_b_i, alu_c_i  in  32 each  ALU operands/result
- alu_zero_i  in  1  ALU Zero flag
- rf_req_o  out  1  RF debug read request
- rf_addr_o  out  5  RF debug read address
- rf_ack_i  in  1  RF read ack; rf_data_i valid this cycle
- rf_data_i  in  32  RF read data
- dm_req_o  out  1  DM debug read request
- dm_addr_o  out  6  DM byte address
- dm_ack_i  in  1  DM read ack
- dm_data_i  in  32  DM read data; only [7:0] used
- disp_data_o  out  32  display word (registered)
- disp_valid_o  out  1  one-cycle pulse after each disp_data_o update
- busy_o  out  1  read in flight
- timeout_o  out  1  one-cycle pulse on an aborted read

## Operation
- Reset values: every output 0; rf_idx = dm_idx = alu_ph = 0; FSM in IDLE; mode_q = 0.
- Mode is valid only if exactly one bit is set. An invalid mode (zero or multi-hot) behaves as the instr view.
- Instr view: disp_data_o <= instr_i every cycle. disp_valid_o stays 0. step_i is ignored.
- ALU view, on step_i: alu_ph selects the word, then increments and wraps 4->0.
  - 0: 32'hFFFFFFFF
  - 1: alu_a_i
  - 2: alu_b_i
  - 3: alu_c_i
  - 4: {31'b0, alu_zero_i}
  - The word is registered directly, with no handshake.
- RF view, on step_i: go to WAIT with rf_req_o=1, rf_addr_o=rf_idx. On ack: disp_data_o <= rf_data_i, rf_idx += 1 (wraps 31->0).
- DM view, on step_i:
  - If dm_idx == DM_DATA_NUM: disp_data_o <= 32'hFFFFFFFF, dm_idx <= 0, no request.
  - Otherwise issue dm_req_o with dm_addr_o=dm_idx. On ack: disp_data_o <= {24'b0, dm_data_i[7:0]}, dm_idx += 1.
- FSM has two states, IDLE and WAIT.
  - IDLE -> WAIT on step_i when a read is needed.
  - WAIT -> IDLE on ack, timeout, or mode change.
- Request rules: req stays high and address stays stable until ack. Only the port matching the current view is ever asserted. Acks arriving in IDLE are ignored.
- Timeout: a cycle counter in WAIT reaches ACK_TIMEOUT with no ack. Then req drops, disp_data_o <= 32'hDEADDEAD, the index advances as on an ack, and timeout_o pulses.
- step_i while busy_o=1 is dropped (not queued).
- Mode change (mode_i != mode_q, checked every cycle):
  - rf_idx, dm_idx and alu_ph clear to 0.
  - Any in-flight request aborts next cycle with no display update and no timeout pulse.
  - disp_data_o holds its last value until the next step, except in the instr view.
- Simultaneous step_i and mode change: the mode change wins and the step is dropped.

## Timing
- step_i is sampled at edge T.
  - Handshake views: req is high in cycle T+1. An ack in T+1 updates disp_data_o at the end of T+1. disp_valid_o is high in T+2 and req is low in T+2. Minimum latency is 2 cycles; maximum is ACK_TIMEOUT+1.
  - ALU view and DM end marker: disp_data_o updates at edge T+1, and disp_valid_o pulses in T+1.
- busy_o = (state == WAIT), registered.
- Asserting rstn low mid-WAIT drops req asynchronously. All state returns to reset values.

## Test plan
- Reset: rstn low during a pending rf_req -> all outputs 0 immediately. After release, mode=4'b1000 with instr_i=32'h00A00093 -> disp_data_o=32'h00A00093 one cycle later.
- RF scan: mode=4'b0100, ack after 3 cycles returning 32'h1000+addr, 33 steps -> disp sequence 0x1000..0x101F then 0x1000. rf_addr_o wraps 31->0. disp_valid_o pulses exactly 33 times.
- DM scan, DM_DATA_NUM=7: data 32'hABCD12<addr> with same-cycle ack -> displays 0x00..0x06, then FFFFFFFF, then 0x00 on the 9th step. No request is issued on the marker step.
- ALU cycle: A=5, B=7, C=12, Zero=0, six steps -> FFFFFFFF, 5, 7, 12, 0, FFFFFFFF.
- Timeout: RF view with ack never given -> req high for exactly 15 cycles, disp_data_o=DEADDEAD, timeout_o pulses once, rf_idx advanced to 1.
- Mode change mid-WAIT: switch RF->DM while req is pending -> rf_req_o low next cycle, no disp update, no timeout. The next step reads DM addr 0. A step issued in the switch cycle is dropped.
